frame_mem_arbiter: RTL and testbench

- Shares the single-port 12-bit frame buffer block RAM among three sources: the VGA pixel-fetch path, a game-logic pixel writer and a built-in screen-fill engine.
- The display read has absolute priority every cycle. Writes are buffered in a small FIFO and drained into idle memory cycles, normally blanking.
- Sits between mem_addr_gen/vga_controller and the frame RAM, in the 25 MHz pixel clock domain.

---
 rtl/frame_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_frame_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_arbiter.sv
// Frame-buffer port arbiter: display reads win every cycle, buffered pixel writes and
// a whole-screen fill engine use the remaining idle RAM cycles.
module frame_mem_arbiter #(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned MEM_DEPTH  = 76800,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [CntW-1:0]   FifoFull = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0]   PtrLast  = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StFlush, StFill, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0] fill_color_q;
    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;

    logic fifo_empty, fifo_full, push, pop, fill_wr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FifoFull);
    assign push       = wr_valid && wr_ready;
    assign pop        = !disp_req && !fifo_empty && (state_q == StIdle || state_q == StFlush);
    assign fill_wr    = (state_q == StFill) && !disp_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (fill_start) state_d = StFlush;
            StFlush: if (fifo_empty) state_d = StFill;
            StFill:  if (fill_wr && fill_cnt_q == LastAddr) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Single RAM port: display read, then fill write, then FIFO drain.
    always_comb begin
        wr_ready  = !fifo_full && (state_q == StIdle);
        fill_busy = (state_q == StFlush) || (state_q == StFill);
        fill_done = (state_q == StDone);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (disp_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (fill_wr) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = fill_cnt_q;
            mem_din  = fill_color_q;
        end else if (pop) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = fifo_addr_q[rptr_q];
            mem_din  = fifo_data_q[rptr_q];
        end
    end

    // Counter holds at the last address while in DONE so it never passes MEM_DEPTH-1.
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        if (state_q == StFlush || state_q == StDone) begin
            fill_cnt_d = '0;
        end else if (fill_wr && fill_cnt_q != LastAddr) begin
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_cnt_q   <= '0;
            fill_color_q <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            if (state_q == StIdle && fill_start) fill_color_q <= fill_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_addr_q[wptr_q] <= wr_addr;
                fifo_data_q[wptr_q] <= wr_data;
                wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            disp_valid_q <= disp_req;
            if (disp_valid_q) disp_data_q <= mem_dout;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_valid_q ? mem_dout : disp_data_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter: stimulus queues expected reads/writes,
// a negedge monitor pops and compares whatever the RAM port and display path present.
module tb_frame_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        disp_req;
    logic [16:0] disp_addr;
    logic        disp_valid;
    logic [11:0] disp_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        fill_start;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [11:0] mem_din;
    logic [11:0] mem_dout;

    frame_mem_arbiter #(
        .ADDR_W    (17),
        .DATA_W    (12),
        .MEM_DEPTH (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_valid(disp_valid),
        .disp_data (disp_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .fill_start(fill_start),
        .fill_color(fill_color),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_wr_cyc = -10;
    bit          prev_req = 0;
    logic [11:0] exp_rd[$];
    logic [28:0] exp_wr[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM model: read data is address + 0x100 with one cycle of latency.
    initial begin
        mem_dout = '0;
        forever begin
            @(posedge clk);
            if (mem_en && !mem_we) mem_dout <= mem_addr[11:0] + 12'h100;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s got event want none", name);
    endtask

    // Monitor: display latency/data, display grant, and every RAM write in order.
    initial forever begin
        logic [11:0] er;
        logic [28:0] ew;
        @(negedge clk);
        if (rst) begin
            chk("disp_valid_latency", disp_valid, prev_req);
            if (disp_valid) begin
                if (exp_rd.size() == 0) flag("unexpected_read");
                else begin
                    er = exp_rd.pop_front();
                    chk("disp_data", disp_data, er);
                end
            end
            if (disp_req) begin
                chk("disp_grant", {mem_en, mem_we, mem_addr}, {2'b10, disp_addr});
            end
            if (mem_en && mem_we) begin
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) flag("unexpected_write");
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_mem_addr", mem_addr, ew[28:12]);
                    chk("wr_mem_din", mem_din, ew[11:0]);
                end
            end
            prev_req = disp_req;
        end else begin
            prev_req = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_disp();
        if (disp_req) exp_rd.push_back(disp_addr[11:0] + 12'h100);
    endtask

    task automatic offer(input logic [16:0] a, input logic [11:0] d, input logic exp_rdy);
        wr_valid = 1;
        wr_addr  = a;
        wr_data  = d;
        note_disp();
        if (exp_rdy) exp_wr.push_back({a, d});
        @(negedge clk);
        chk("wr_ready", wr_ready, exp_rdy);
        tick();
        wr_valid = 0;
    endtask

    task automatic run_fill(input logic [11:0] color, input bit every3, input bit poke);
        bit done;
        fill_start = 1;
        fill_color = color;
        disp_req   = 0;
        for (int i = 0; i < 16; i++) exp_wr.push_back({17'(i), color});
        @(negedge clk);
        chk("fill_busy_start", fill_busy, 0);
        tick();
        fill_start = 0;
        done = 0;
        for (int k = 1; k < 200 && !done; k++) begin
            disp_req  = every3 && (k % 3 == 0);
            disp_addr = 17'(k + 'h40);
            if (poke && k == 5) begin
                fill_start = 1;
                fill_color = 12'hBAD;
            end else begin
                fill_start = 0;
            end
            note_disp();
            @(negedge clk);
            if (fill_done) begin
                done = 1;
                chk("fill_busy_in_done", fill_busy, 0);
                chk("done_after_last_wr", cyc, last_wr_cyc + 1);
                chk("fill_writes_left", exp_wr.size(), 0);
            end else begin
                chk("fill_busy", fill_busy, 1);
                chk("wr_ready_busy", wr_ready, 0);
            end
            tick();
        end
        disp_req   = 0;
        fill_start = 0;
        if (!done) flag("fill_done_timeout");
        @(negedge clk);
        chk("fill_done_one_cycle", fill_done, 0);
        chk("fill_busy_after", fill_busy, 0);
        chk("wr_ready_after", wr_ready, 1);
        tick();
    endtask

    initial begin
        bit found;
        rst = 0; disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        fill_start = 0; fill_color = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_fill_busy", fill_busy, 0);
        chk("rst_fill_done", fill_done, 0);
        tick();
        rst = 1;
        @(negedge clk);
        chk("wr_ready_post_rst", wr_ready, 1);
        tick();

        // Display only
        for (int i = 0; i < 3; i++) begin
            disp_req  = 1;
            disp_addr = 17'(i);
            note_disp();
            tick();
        end
        disp_req = 0;
        tick();
        @(negedge clk);
        chk("disp_hold_valid", disp_valid, 0);
        chk("disp_hold_data", disp_data, 12'h102);
        tick();

        // FIFO fills during active video, drains once the display goes idle
        disp_req  = 1;
        disp_addr = 17'h20;
        offer(17'h100, 12'h111, 1);
        offer(17'h101, 12'h222, 1);
        offer(17'h102, 12'h333, 1);
        offer(17'h103, 12'h444, 1);
        offer(17'h104, 12'h555, 0);
        disp_req = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_we", mem_we, 1);
            chk("drain_wr_ready", wr_ready, (k != 0));
            tick();
        end
        @(negedge clk);
        chk("drain_end_we", mem_we, 0);
        tick();

        // Simultaneous push and pop
        disp_req  = 1;
        disp_addr = 17'h30;
        offer(17'h200, 12'hA01, 1);
        offer(17'h201, 12'hA02, 1);
        disp_req = 0;
        offer(17'h202, 12'hA03, 1);
        offer(17'h203, 12'hA04, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pushpop_tail_we", mem_we, (k < 2));
            tick();
        end

        // Fill with two pending FIFO entries; a stray fill_start mid-fill is ignored
        disp_req  = 1;
        disp_addr = 17'h50;
        offer(17'h300, 12'h0E1, 1);
        offer(17'h301, 12'h0E2, 1);
        run_fill(12'hF00, 0, 1);

        // Fill interleaved with display reads every third cycle
        run_fill(12'h0A5, 1, 0);

        // Reset in the middle of a fill, at address 7
        fill_start = 1;
        fill_color = 12'h0F0;
        for (int i = 0; i < 8; i++) exp_wr.push_back({17'(i), 12'h0F0});
        tick();
        fill_start = 0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (mem_en && mem_we && mem_addr == 17'd7) found = 1;
            else tick();
        end
        if (!found) flag("reach_addr7_timeout");
        #1 rst = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("abort_we", mem_we, 0);
        chk("abort_busy", fill_busy, 0);
        chk("abort_done", fill_done, 0);
        chk("abort_wr_ready", wr_ready, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", fill_done, 0);
            tick();
        end
        run_fill(12'h123, 0, 0);

        tick();
        tick();
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
